lpif_dstrm_flit_buffer: RTL

// - Consumes the LPIF downstream flit interface (dstrm_*) of the x4 H1 slave link and buffers beats for the adapter/consumer.
// - Source has no backpressure, so the block provides valid/ready decoupling, overflow detection and a registered LPIF state tracker.
// - Sits directly downstream of the LPIF slave top, in the same clk_wr domain.

---
 rtl/lpif_dstrm_pkg.sv | 29 ++
 rtl/lpif_dstrm_fifo.sv | 56 +++++
 rtl/lpif_dstrm_flit_buffer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/lpif_dstrm_pkg.sv
// Shared types for the LPIF downstream flit buffer.
// Entry layout depends on LPIF_DSTRM_CRC_STORE_EN (CRC fields stored per entry when defined).
package lpif_dstrm_pkg;

    typedef enum logic [1:0] {
        OFFLINE = 2'd0,
        RUN     = 2'd1,
        FLUSH   = 2'd2
    } fsm_state_e;

    localparam logic [3:0] LPIF_STATE_RESET = 4'h0;

`ifdef LPIF_DSTRM_CRC_STORE_EN
    typedef struct packed {
        logic        crc_valid;
        logic [15:0] crc;
        logic [1:0]  protid;
        logic [255:0] data;
    } entry_t;
`else
    typedef struct packed {
        logic [1:0]  protid;
        logic [255:0] data;
    } entry_t;
`endif

    localparam int unsigned ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/lpif_dstrm_fifo.sv
// Synchronous FIFO with registered storage, synchronous flush and occupancy count.
// Caller guarantees no write when full unless a read happens in the same cycle.
module lpif_dstrm_fifo #(
    parameter  int unsigned WIDTH  = 8,
    parameter  int unsigned DEPTH  = 8,
    localparam int unsigned AWIDTH = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data,
    output logic              full,
    output logic              empty,
    output logic [AWIDTH:0]   occupancy
);

    localparam int unsigned CW = AWIDTH + 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;
    logic [CW-1:0]     count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AWIDTH'(1);
            if (rd_en) rd_ptr <= rd_ptr + AWIDTH'(1);
            if (wr_en && !rd_en)
                count <= count + CW'(1);
            else if (!wr_en && rd_en)
                count <= count - CW'(1);
        end
    end

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) mem[wr_ptr] <= wr_data;
    end

    assign rd_data   = mem[rd_ptr];
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign occupancy = count;

endmodule

// File: rtl/lpif_dstrm_flit_buffer.sv
// LPIF downstream flit buffer: link FSM, overflow/drop tracking, LPIF state tracker.
// Define LPIF_DSTRM_CRC_STORE_EN to store and present per-beat CRC.
module lpif_dstrm_flit_buffer
    import lpif_dstrm_pkg::*;
#(
    parameter  int unsigned DEPTH  = 8,
    localparam int unsigned AWIDTH = $clog2(DEPTH)
) (
    input  logic         clk_wr,
    input  logic         rst_wr_n,
    input  logic         rx_online,
    input  logic [3:0]   dstrm_state,
    input  logic [1:0]   dstrm_protid,
    input  logic [255:0] dstrm_data,
    input  logic         dstrm_dvalid,
    input  logic [15:0]  dstrm_crc,
    input  logic         dstrm_crc_valid,
    input  logic         dstrm_valid,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   out_protid,
    output logic [255:0] out_data,
    output logic [15:0]  out_crc,
    output logic         out_crc_valid,
    output logic [3:0]   lpif_state,
    output logic         state_chg,
    input  logic         clr_err,
    output logic [31:0]  dbg_status
);

    fsm_state_e state_q, state_d;

    logic          push, pop, drop, wr_en;
    logic          fifo_full, fifo_empty;
    logic [AWIDTH:0] occupancy;
    logic [3:0]    occ_nib;
    entry_t        wr_entry, rd_entry, head;
    logic          overflow;
    logic [15:0]   drop_cnt;

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) state_q <= OFFLINE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            OFFLINE: if (rx_online)  state_d = RUN;
            RUN:     if (!rx_online) state_d = FLUSH;
            FLUSH:                   state_d = OFFLINE;
            default:                 state_d = OFFLINE;
        endcase
    end

    assign push      = (state_q == RUN) && dstrm_valid && dstrm_dvalid;
    assign out_valid = !fifo_empty && (state_q != FLUSH);
    assign pop       = out_valid && out_ready;
    // A full FIFO still takes the beat when the head leaves in the same cycle.
    assign drop      = push && fifo_full && !pop;
    assign wr_en     = push && !drop;

`ifdef LPIF_DSTRM_CRC_STORE_EN
    assign wr_entry = '{crc_valid: dstrm_crc_valid, crc: dstrm_crc,
                        protid: dstrm_protid, data: dstrm_data};
`else
    logic unused_crc;
    assign unused_crc = ^{dstrm_crc, dstrm_crc_valid};
    assign wr_entry   = '{protid: dstrm_protid, data: dstrm_data};
`endif

    lpif_dstrm_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk_wr),
        .rst_n     (rst_wr_n),
        .flush     (state_q == FLUSH),
        .wr_en     (wr_en),
        .wr_data   (wr_entry),
        .rd_en     (pop),
        .rd_data   (rd_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (occupancy)
    );

    assign head       = out_valid ? rd_entry : '0;
    assign out_protid = head.protid;
    assign out_data   = head.data;
`ifdef LPIF_DSTRM_CRC_STORE_EN
    assign out_crc       = head.crc;
    assign out_crc_valid = head.crc_valid;
`else
    assign out_crc       = 16'h0;
    assign out_crc_valid = 1'b0;
`endif

    // Clear takes priority, but a drop in the same cycle is still recorded afterwards.
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clr_err) begin
            overflow <= drop;
            drop_cnt <= drop ? 16'd1 : 16'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            lpif_state <= LPIF_STATE_RESET;
            state_chg  <= 1'b0;
        end else begin
            state_chg <= dstrm_valid && (dstrm_state != lpif_state);
            if (dstrm_valid) lpif_state <= dstrm_state;
        end
    end

    assign occ_nib    = 4'(occupancy);
    assign dbg_status = {overflow, 3'b000, occ_nib, 8'h00, drop_cnt};

endmodule
